// File: rtl/shared_adder_sched_pkg.sv
// Shared definitions for the two-pass, round-robin shared 64-bit adder.
// Holds the FSM encoding, the slice/operand widths and the requester ids.
package shared_adder_sched_pkg;

  localparam int SLICE = 32;
  localparam int WIDTH = 2 * SLICE;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    RESP = 2'd3
  } state_t;

endpackage

// File: rtl/shared_adder_sched_add_slice32.sv
// Combinational 32-bit adder slice with carry in/out; the scheduler reuses
// it for both the low and the high half of every 64-bit add.
module add_slice32
  import shared_adder_sched_pkg::*;
(
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             c_in,
  output logic [SLICE-1:0] sum,
  output logic             c_out
);

  logic [SLICE:0] full;

  assign full  = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, c_in};
  assign sum   = full[SLICE-1:0];
  assign c_out = full[SLICE];

endmodule

// File: rtl/shared_adder_sched.sv
// Round-robin scheduler sharing one 32-bit adder slice between two 64-bit
// add requesters; each add takes a low pass and a high pass, then a response.
module shared_adder_sched
  import shared_adder_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_c_in,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_c_in,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_c_out,
  output logic             busy
);

  state_t           state;
  logic             last_grant;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_c_in;
  logic             op_id;
  logic             carry_mid;

  logic             grant_valid;
  logic             grant_id;

  logic [SLICE-1:0] slice_a;
  logic [SLICE-1:0] slice_b;
  logic             slice_c_in;
  logic [SLICE-1:0] slice_sum;
  logic             slice_c_out;

  // With both requesters pending, the one that did not win last time goes next.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    grant_valid = req0_valid || req1_valid;
    grant_id    = REQ0;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_grant;
    end else if (req1_valid) begin
      grant_id = REQ1;
    end
  end

  assign req0_ready = (state == IDLE) && grant_valid && (grant_id == REQ0);
  assign req1_ready = (state == IDLE) && grant_valid && (grant_id == REQ1);

  // The high pass sees only the registered carry from the low pass.
  always_comb begin
    slice_a    = op_a[SLICE-1:0];
    slice_b    = op_b[SLICE-1:0];
    slice_c_in = op_c_in;
    if (state == HI) begin
      slice_a    = op_a[WIDTH-1:SLICE];
      slice_b    = op_b[WIDTH-1:SLICE];
      slice_c_in = carry_mid;
    end
  end

  add_slice32 u_slice (
    .a     (slice_a),
    .b     (slice_b),
    .c_in  (slice_c_in),
    .sum   (slice_sum),
    .c_out (slice_c_out)
  );

  // NOTE: state is updated with non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= REQ1;
      op_a       <= '0;
      op_b       <= '0;
      op_c_in    <= 1'b0;
      op_id      <= REQ0;
      carry_mid  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= REQ0;
      rsp_sum    <= '0;
      rsp_c_out  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            op_a    <= (grant_id == REQ1) ? req1_a    : req0_a;
            op_b    <= (grant_id == REQ1) ? req1_b    : req0_b;
            op_c_in <= (grant_id == REQ1) ? req1_c_in : req0_c_in;
            op_id   <= grant_id;
            busy    <= 1'b1;
            state   <= LO;
          end
        end
        LO: begin
          rsp_sum[SLICE-1:0] <= slice_sum;
          carry_mid          <= slice_c_out;
          state              <= HI;
        end
        HI: begin
          rsp_sum[WIDTH-1:SLICE] <= slice_sum;
          rsp_c_out              <= slice_c_out;
          rsp_id                 <= op_id;
          rsp_valid              <= 1'b1;
          state                  <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid  <= 1'b0;
            busy       <= 1'b0;
            last_grant <= rsp_id;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shared_adder_sched.sv
// Directed self-checking bench for shared_adder_sched: reset, single ops,
// carry propagation, round-robin contention, backpressure and mid-op reset.
module tb_shared_adder_sched;

  logic        clk;
  logic        rst_n;
  logic        req0_valid;
  logic        req0_ready;
  logic [63:0] req0_a;
  logic [63:0] req0_b;
  logic        req0_c_in;
  logic        req1_valid;
  logic        req1_ready;
  logic [63:0] req1_a;
  logic [63:0] req1_b;
  logic        req1_c_in;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [63:0] rsp_sum;
  logic        rsp_c_out;
  logic        busy;

  int checks = 0;
  int errors = 0;

  shared_adder_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_c_in  (req0_c_in),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_c_in  (req1_c_in),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_sum    (rsp_sum),
    .rsp_c_out  (rsp_c_out),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one op on the chosen requester, drops valid after acceptance and
  // returns at a falling edge with rsp_valid high (ok=1) or on timeout (ok=0).
  task automatic issue_and_wait(input logic id, input logic [63:0] a,
                                input logic [63:0] b, input logic c,
                                output bit ok);
    bit accepted;
    accepted = 1'b0;
    ok       = 1'b0;
    @(negedge clk);
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_c_in = c;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_c_in = c;
    end
    for (int i = 0; i < 8 && !accepted; i++) begin
      #1;
      if (id ? req1_ready : req0_ready) accepted = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    if (accepted) begin
      for (int i = 0; i < 8; i++) begin
        if (rsp_valid) begin
          ok = 1'b1;
          break;
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_c_in = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_c_in = 1'b0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_id !== 1'b0 ||
        rsp_sum !== 64'd0 || rsp_c_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b busy=%b id=%b sum=%h c=%b exp all zero",
               rsp_valid, busy, rsp_id, rsp_sum, rsp_c_out);
    end
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready got r0=%b r1=%b exp 0 0", req0_ready, req1_ready);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 64'd1; req0_b = 64'd1; req0_c_in = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_ready got r0=%b r1=%b exp 1 0", req0_ready, req1_ready);
    end
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || rsp_valid !== 1'b0 || req0_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_lo got busy=%b v=%b r0=%b exp 1 0 0", busy, rsp_valid, req0_ready);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_hi_early got v=%b exp 0", rsp_valid);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_sum !== 64'd3 || rsp_c_out !== 1'b0 || rsp_id !== 1'b0) begin
      errors++;
      $display("FAIL single_rsp got v=%b sum=%h c=%b id=%b exp 1 3 0 0",
               rsp_valid, rsp_sum, rsp_c_out, rsp_id);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_done got v=%b busy=%b exp 0 0", rsp_valid, busy);
    end
  endtask

  task automatic test_mid_carry();
    bit ok;
    issue_and_wait(1'b1, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_00BA, 1'b1, ok);
    checks++;
    if (!ok || rsp_sum !== 64'h0000_0001_0000_00BA || rsp_c_out !== 1'b0 || rsp_id !== 1'b1) begin
      errors++;
      $display("FAIL mid_carry got ok=%b sum=%h c=%b id=%b exp 1 0000000100000 0ba 0 1",
               ok, rsp_sum, rsp_c_out, rsp_id);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_overflow();
    bit ok;
    issue_and_wait(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, ok);
    checks++;
    if (!ok || rsp_sum !== 64'd1 || rsp_c_out !== 1'b1 || rsp_id !== 1'b0) begin
      errors++;
      $display("FAIL overflow got ok=%b sum=%h c=%b id=%b exp 1 1 1 0",
               ok, rsp_sum, rsp_c_out, rsp_id);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  // Both requesters held valid; rsp_ready held high also covers it being
  // ignored outside RESP.
  task automatic test_contention();
    logic [63:0] exp_sum;
    int          cyc;
    int          last_cyc;
    bit          seen;
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 64'h0123_4567_89AB_CDEF;
    req0_b = 64'hFEDC_BA98_7654_3210; req0_c_in = 1'b0;
    req1_valid = 1'b1; req1_a = 64'hF; req1_b = 64'hF; req1_c_in = 1'b0;
    rsp_ready = 1'b1;
    cyc = 0;
    last_cyc = 0;
    for (int n = 0; n < 4; n++) begin
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        cyc++;
        if (rsp_valid) begin
          seen = 1'b1;
          break;
        end
      end
      if (n == 3) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      exp_sum = (n % 2 == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h1E;
      checks++;
      if (!seen || rsp_id !== 1'(n % 2) || rsp_sum !== exp_sum || rsp_c_out !== 1'b0) begin
        errors++;
        $display("FAIL contention_op%0d got seen=%b id=%b sum=%h c=%b exp 1 %0d %h 0",
                 n, seen, rsp_id, rsp_sum, rsp_c_out, n % 2, exp_sum);
      end
      checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++;
        $display("FAIL contention_overlap%0d got r0=%b r1=%b exp 0 0", n, req0_ready, req1_ready);
      end
      if (n > 0) begin
        checks++;
        if (cyc - last_cyc != 4) begin
          errors++;
          $display("FAIL contention_interval%0d got %0d exp 4", n, cyc - last_cyc);
        end
      end
      last_cyc = cyc;
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL contention_idle got busy=%b v=%b exp 0 0", busy, rsp_valid);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    issue_and_wait(1'b0, 64'h0000_0001_0000_0000, 64'd2, 1'b0, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL backpressure_rsp got timeout exp rsp_valid");
    end
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_sum !== 64'h0000_0001_0000_0002 || rsp_id !== 1'b0 ||
          rsp_c_out !== 1'b0 || busy !== 1'b1 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold%0d got v=%b sum=%h id=%b c=%b busy=%b r0=%b r1=%b exp 1 100000002 0 0 1 0 0",
                 i, rsp_valid, rsp_sum, rsp_id, rsp_c_out, busy, req0_ready, req1_ready);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_release got v=%b busy=%b r0=%b r1=%b exp 0 0 0 1",
               rsp_valid, busy, req0_ready, req1_ready);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    req1_valid = 1'b1; req1_a = 64'd5; req1_b = 64'd6; req1_c_in = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_in_hi got busy=%b v=%b exp 1 0", busy, rsp_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async got v=%b busy=%b exp 0 0", rsp_valid, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_first_grant got r0=%b r1=%b exp 1 0", req0_ready, req1_ready);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_stale%0d got v=%b busy=%b exp 0 0", i, rsp_valid, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_mid_carry();
    test_contention();
    test_overflow();
    test_backpressure();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
